// File: rtl/tinycpu_ram_bridge_if.sv
// Bus bundle between tinycpu, the load/store bridge and the RAM0 port.
// master: the bridge's view (takes CPU requests, drives the RAM handshake).
// slave:  the surrounding CPU/RAM view.
interface tinycpu_ram_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_busy;

  logic [31:0] ram_raddr;
  logic [31:0] ram_rdata;
  logic        ram_ren;
  logic        ram_rvalid;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic        ram_wen;
  logic [3:0]  ram_sel;
  logic        ram_wready;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_ack, cpu_err, cpu_busy,
    output ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen, ram_sel,
    input  ram_rdata, ram_rvalid, ram_wready
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_ack, cpu_err, cpu_busy,
    input  ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen, ram_sel,
    output ram_rdata, ram_rvalid, ram_wready
  );
endinterface

// File: rtl/tinycpu_ram_bridge.sv
// tinycpu_ram_bridge: single-outstanding load/store bridge from tinycpu to RAM0.
// Optional wait timeout enabled by defining RAM_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for cpu_req; address checked and request latched here
// RD_WAIT | ram_ren held until ram_rvalid, read data captured
// WR_WAIT | ram_wen held until ram_wready
// RESP    | one-cycle cpu_ack or cpu_err to the CPU
module tinycpu_ram_bridge #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0400_0000
`ifdef RAM_BRIDGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input logic clk,
  input logic rst,
  tinycpu_ram_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        err_q, err_next;
  logic        addr_bad;

  assign addr_bad = (bus.cpu_addr[1:0] != 2'b00) || (bus.cpu_addr >= ADDR_LIMIT);

`ifdef RAM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO = TIMEOUT[7:0];
  logic [7:0] cnt;
  logic       tmo_hit;

  // the limit is reached in the wait cycle whose index (1-based) equals TIMEOUT
  assign tmo_hit = ((cnt + 8'd1) == TMO);

  // wait-cycle counter: zero outside the wait states, so it starts at 0 on entry
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 8'd0;
    else if ((state == RD_WAIT) || (state == WR_WAIT))
      cnt <= cnt + 8'd1;
    else
      cnt <= 8'd0;
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // next-state logic; a handshake in the limit cycle takes priority over the timeout
  always_comb begin
    state_next = state;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (addr_bad) begin
            state_next = RESP;
            err_next   = 1'b1;
          end else if (bus.cpu_we && (bus.cpu_be == 4'b0000)) begin
            state_next = RESP;
            err_next   = 1'b0;
          end else if (bus.cpu_we) begin
            state_next = WR_WAIT;
            err_next   = 1'b0;
          end else begin
            state_next = RD_WAIT;
            err_next   = 1'b0;
          end
        end
      end
      RD_WAIT: begin
        if (bus.ram_rvalid) begin
          state_next = RESP;
        end else if (tmo_hit) begin
          state_next = RESP;
          err_next   = 1'b1;
        end
      end
      WR_WAIT: begin
        if (bus.ram_wready) begin
          state_next = RESP;
        end else if (tmo_hit) begin
          state_next = RESP;
          err_next   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // request latch, response flag and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      err_q <= err_next;
      if ((state == IDLE) && bus.cpu_req) begin
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
        be_q    <= bus.cpu_be;
      end
      if ((state == RD_WAIT) && bus.ram_rvalid)
        rdata_q <= bus.ram_rdata;
    end
  end

  // outputs decode straight from state so ren/wen drop the cycle the FSM leaves a wait state
  assign bus.ram_ren   = (state == RD_WAIT);
  assign bus.ram_raddr = (state == RD_WAIT) ? addr_q : 32'd0;
  assign bus.ram_wen   = (state == WR_WAIT);
  assign bus.ram_waddr = (state == WR_WAIT) ? addr_q : 32'd0;
  assign bus.ram_wdata = (state == WR_WAIT) ? wdata_q : 32'd0;
  assign bus.ram_sel   = (state == WR_WAIT) ? be_q : 4'd0;

  assign bus.cpu_ack   = (state == RESP) && !err_q;
  assign bus.cpu_err   = (state == RESP) && err_q;
  assign bus.cpu_busy  = (state != IDLE);
  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_tinycpu_ram_bridge.sv
// Scoreboard bench for tinycpu_ram_bridge: stimulus pushes expected responses,
// a forked monitor pops and compares them whenever cpu_ack/cpu_err is seen.
module tb_tinycpu_ram_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tinycpu_ram_bridge_if bif ();

`ifdef RAM_BRIDGE_TIMEOUT_EN
  tinycpu_ram_bridge #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bif));
`else
  tinycpu_ram_bridge dut (.clk(clk), .rst(rst), .bus(bif));
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  logic seen_ren, seen_wen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // drive one request; returns #1 after the accepting edge (first post-accept cycle)
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit push, input logic err,
                       input bit chk, input logic [31:0] data, input int lat);
    exp_t e;
    @(posedge clk); #1;
    bif.cpu_req   = 1'b1;
    bif.cpu_we    = we;
    bif.cpu_addr  = a;
    bif.cpu_wdata = d;
    bif.cpu_be    = be;
    e.err      = err;
    e.chk_data = chk;
    e.data     = data;
    e.at_cyc   = (lat < 0) ? -1 : cyc + lat;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    bif.cpu_req   = 1'b0;
    bif.cpu_we    = ~we;
    bif.cpu_addr  = ~a;
    bif.cpu_wdata = ~d;
    bif.cpu_be    = ~be;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bif.cpu_busy) return;
    end
    check("idle_timeout", {31'd0, bif.cpu_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wen_cycles;
    bif.cpu_req = 0; bif.cpu_we = 0; bif.cpu_addr = 0; bif.cpu_wdata = 0; bif.cpu_be = 0;
    bif.ram_rdata = 0; bif.ram_rvalid = 0; bif.ram_wready = 0;
    seen_ren = 0; seen_wen = 0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (bif.ram_ren) seen_ren = 1'b1;
          if (bif.ram_wen) seen_wen = 1'b1;
          if (bif.ram_ren || bif.ram_wen)
            check("ren_wen_exclusive", {31'd0, bif.ram_ren & bif.ram_wen}, 32'd0);
          if (bif.cpu_ack || bif.cpu_err) begin
            if (exp_q.size() == 0) begin
              check("unexpected_resp", {30'd0, bif.cpu_ack, bif.cpu_err}, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("resp_err", {31'd0, bif.cpu_err}, {31'd0, e.err});
              check("resp_ack", {31'd0, bif.cpu_ack}, {31'd0, ~e.err});
              if (e.at_cyc >= 0) check("resp_cycle", cyc, e.at_cyc);
              if (e.chk_data) check("resp_rdata", bif.cpu_rdata, e.data);
              check("resp_ren_wen_low", {30'd0, bif.ram_ren, bif.ram_wen}, 32'd0);
            end
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {31'd0, bif.cpu_busy}, 32'd0);
    check("rst_ack_err", {30'd0, bif.cpu_ack, bif.cpu_err}, 32'd0);
    check("rst_ren_wen", {30'd0, bif.ram_ren, bif.ram_wen}, 32'd0);
    check("rst_rdata", bif.cpu_rdata, 32'd0);
    check("rst_waddr", bif.ram_waddr, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: write then read back with 3-cycle read latency
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 0, 32'd0, -1);
    @(negedge clk);
    check("t1_wen", {31'd0, bif.ram_wen}, 32'd1);
    check("t1_waddr", bif.ram_waddr, 32'h10);
    check("t1_wdata", bif.ram_wdata, 32'hDEAD_BEEF);
    check("t1_sel", {28'd0, bif.ram_sel}, 32'hF);
    @(posedge clk); #1 bif.ram_wready = 1'b1;
    @(posedge clk); #1 bif.ram_wready = 1'b0;
    wait_idle();
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1, 1'b0, 1, 32'hDEAD_BEEF, -1);
    @(negedge clk);
    check("t1_ren", {31'd0, bif.ram_ren}, 32'd1);
    check("t1_raddr", bif.ram_raddr, 32'h10);
    check("t1_waddr_idle", bif.ram_waddr, 32'd0);
    repeat (2) @(posedge clk);
    #1 bif.ram_rvalid = 1'b1; bif.ram_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 bif.ram_rvalid = 1'b0; bif.ram_rdata = 32'd0;
    wait_idle();
    check("t1_ren_dropped", {31'd0, bif.ram_ren}, 32'd0);
    // stray rvalid in IDLE must not be captured
    #1 bif.ram_rvalid = 1'b1; bif.ram_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 bif.ram_rvalid = 1'b0; bif.ram_rdata = 32'd0;
    @(negedge clk);
    check("t1_stray_rvalid", bif.cpu_rdata, 32'hDEAD_BEEF);
    check("t1_stray_busy", {31'd0, bif.cpu_busy}, 32'd0);

    // 2: minimum-latency read, ack 2 cycles after req
    issue(1'b0, 32'h100, 32'd0, 4'h0, 1, 1'b0, 1, 32'hA5A5_0001, 2);
    bif.ram_rvalid = 1'b1; bif.ram_rdata = 32'hA5A5_0001;
    @(negedge clk);
    check("t2_busy_c1", {31'd0, bif.cpu_busy}, 32'd1);
    @(posedge clk); #1 bif.ram_rvalid = 1'b0; bif.ram_rdata = 32'd0;
    @(negedge clk);
    check("t2_busy_c2", {31'd0, bif.cpu_busy}, 32'd1);
    @(negedge clk);
    check("t2_busy_drop", {31'd0, bif.cpu_busy}, 32'd0);
    // last legal word
    issue(1'b0, 32'h03FF_FFFC, 32'd0, 4'h0, 1, 1'b0, 1, 32'h0BAD_F00D, 2);
    bif.ram_rvalid = 1'b1; bif.ram_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1 bif.ram_rvalid = 1'b0; bif.ram_rdata = 32'd0;
    wait_idle();

    // 3: address errors, no RAM cycle, rdata kept
    seen_ren = 0; seen_wen = 0;
    issue(1'b0, 32'h0000_0002, 32'd0, 4'h0, 1, 1'b1, 0, 32'd0, 1);
    wait_idle();
    issue(1'b0, 32'h0400_0000, 32'd0, 4'h0, 1, 1'b1, 0, 32'd0, 1);
    wait_idle();
    issue(1'b1, 32'h0400_0000, 32'h5555_5555, 4'hF, 1, 1'b1, 0, 32'd0, 1);
    wait_idle();
    check("t3_no_ren_wen", {30'd0, seen_ren, seen_wen}, 32'd0);
    check("t3_rdata_kept", bif.cpu_rdata, 32'h0BAD_F00D);

    // 4: empty byte mask, then partial mask
    seen_wen = 0;
    issue(1'b1, 32'h20, 32'hCAFE_CAFE, 4'b0000, 1, 1'b0, 0, 32'd0, 1);
    wait_idle();
    check("t4_no_wen", {31'd0, seen_wen}, 32'd0);
    issue(1'b1, 32'h24, 32'h1122_3344, 4'b0011, 1, 1'b0, 0, 32'd0, -1);
    @(negedge clk);
    check("t4_sel", {28'd0, bif.ram_sel}, 32'h3);
    check("t4_waddr", bif.ram_waddr, 32'h24);
    check("t4_wdata", bif.ram_wdata, 32'h1122_3344);
    bif.ram_wready = 1'b1;
    @(posedge clk); #1 bif.ram_wready = 1'b0;
    wait_idle();

    // 5: reset in RD_WAIT, late rvalid ignored
    issue(1'b0, 32'h30, 32'd0, 4'h0, 0, 1'b0, 0, 32'd0, -1);
    @(negedge clk);
    check("t5_ren", {31'd0, bif.ram_ren}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_ren_wen", {30'd0, bif.ram_ren, bif.ram_wen}, 32'd0);
    check("t5_busy", {31'd0, bif.cpu_busy}, 32'd0);
    check("t5_rdata", bif.cpu_rdata, 32'd0);
    bif.ram_rvalid = 1'b1; bif.ram_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 bif.ram_rvalid = 1'b0; bif.ram_rdata = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check("t5_quiet", {29'd0, bif.cpu_ack, bif.cpu_err, bif.cpu_busy}, 32'd0);
      check("t5_rdata_zero", bif.cpu_rdata, 32'd0);
    end

`ifdef RAM_BRIDGE_TIMEOUT_EN
    // 6: write timeout after 8 wait cycles, then handshake exactly at the limit
    issue(1'b1, 32'h40, 32'h7777_0000, 4'hF, 1, 1'b1, 0, 32'd0, 9);
    wen_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bif.ram_wen) break;
      if (i > 0) wen_cycles++;
    end
    check("t6_wen_cycles", wen_cycles, 32'd8);
    wait_idle();
    issue(1'b1, 32'h44, 32'h7777_0001, 4'hF, 1, 1'b0, 0, 32'd0, 9);
    repeat (7) @(posedge clk);
    #1 bif.ram_wready = 1'b1;
    @(posedge clk); #1 bif.ram_wready = 1'b0;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
